execute_control: RTL

- Execute-side counterpart of the fetch/execute latch in the 2-stage pipeline.
- Consumes the E-stage decoded controls and operands.
- Drives the back-channel signals toward fetch:
  - `stallC` holds the F/E latch during multicycle mul/div/mod.
  - Branch redirect (taken flag and target PC).
  - `flushF` squashes the wrong-path instruction.
- Owns the architectural EQ/GT flags register written by cmp.

---
 rtl/execute_control_if.sv | 51 +++++
 rtl/execute_control.sv | 110 +++++++++++
 2 files changed

// File: rtl/execute_control_if.sv
// rtl/execute_control_if.sv - E-stage control bundle between decode/latch and execute_control
//
// Purpose: groups the E-stage decoded controls/operands and the back-channel
//          outputs toward fetch into one interface.
// Signals:
//   validE, isMulE, isDivE, isModE, isCmpE     E-stage instruction class
//   isBeqE, isBgtE, isUbranchE, isRetE         E-stage branch class
//   op1E, op2E, branchTargetE                  operands / PC-relative target
//   stallC, aluDoneE                           multicycle ALU handshake
//   isBranchTakenE, branchPCE, flushF          fetch redirect
//   flagEQ, flagGT                             architectural compare flags
// Modports: master drives the E-stage inputs, slave is execute_control.
interface execute_control_if #(
    parameter int WIDTH = 32
) ();
    logic             validE;
    logic             isMulE;
    logic             isDivE;
    logic             isModE;
    logic             isCmpE;
    logic             isBeqE;
    logic             isBgtE;
    logic             isUbranchE;
    logic             isRetE;
    logic [WIDTH-1:0] op1E;
    logic [WIDTH-1:0] op2E;
    logic [WIDTH-1:0] branchTargetE;
    logic             stallC;
    logic             aluDoneE;
    logic             isBranchTakenE;
    logic [WIDTH-1:0] branchPCE;
    logic             flushF;
    logic             flagEQ;
    logic             flagGT;

    modport master (
        output validE, isMulE, isDivE, isModE, isCmpE,
        output isBeqE, isBgtE, isUbranchE, isRetE,
        output op1E, op2E, branchTargetE,
        input  stallC, aluDoneE, isBranchTakenE, branchPCE, flushF,
        input  flagEQ, flagGT
    );

    modport slave (
        input  validE, isMulE, isDivE, isModE, isCmpE,
        input  isBeqE, isBgtE, isUbranchE, isRetE,
        input  op1E, op2E, branchTargetE,
        output stallC, aluDoneE, isBranchTakenE, branchPCE, flushF,
        output flagEQ, flagGT
    );
endinterface

// File: rtl/execute_control.sv
// rtl/execute_control.sv - execute-stage stall, branch redirect and flag control
//
// Purpose: stalls the F/E latch while a multicycle mul/div/mod occupies E,
//          resolves branches from the registered EQ/GT flags, and owns the
//          flags register written by cmp.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    execute_control_if.slave (E-stage controls in, back-channel out)
module execute_control #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    execute_control_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Counter load is N-2: the IDLE cycle and the final cnt==0 cycle account
    // for the other two cycles of residency.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES >= 2) ? DIV_CYCLES - 2 : 0);
    localparam logic             MUL_ONE  = (MUL_CYCLES < 2);
    localparam logic             DIV_ONE  = (DIV_CYCLES < 2);

    logic [0:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             flag_eq, flag_gt;
    logic             stall, alu_done, taken;
    logic             longop, single_cycle;
    logic [CNT_W-1:0] load_val;
    logic [WIDTH-1:0] op1, op2;

    assign op1 = bus.op1E;
    assign op2 = bus.op2E;

    assign longop       = bus.validE & (bus.isMulE | bus.isDivE | bus.isModE);
    // Decode is one-hot; mul wins if several long-op bits are set anyway.
    assign single_cycle = bus.isMulE ? MUL_ONE : DIV_ONE;
    assign load_val     = bus.isMulE ? MUL_LOAD : DIV_LOAD;

    always_comb begin
        stall      = 1'b0;
        alu_done   = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        // Outputs are gated by reset so the stall drops asynchronously.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (longop && !single_cycle) begin
                        stall      = 1'b1;
                        cnt_next   = load_val;
                        state_next = BUSY;
                    end else if (longop) begin
                        alu_done = 1'b1;
                    end else begin
                        alu_done = bus.validE;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        stall    = 1'b1;
                        cnt_next = cnt - CNT_W'(1);
                    end else begin
                        alu_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            flag_eq <= 1'b0;
            flag_gt <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (bus.validE && bus.isCmpE && !stall) begin
                flag_eq <= (op1 == op2);
                flag_gt <= ($signed(op1) > $signed(op2));
            end
        end
    end

    // Stall has priority: a branch coinciding with a long op waits.
    assign taken = reset & bus.validE & ~stall &
                   (bus.isUbranchE | bus.isRetE |
                    (bus.isBeqE & flag_eq) | (bus.isBgtE & flag_gt));

    assign bus.stallC         = stall;
    assign bus.aluDoneE       = alu_done;
    assign bus.isBranchTakenE = taken;
    assign bus.flushF         = taken;
    assign bus.branchPCE      = bus.isRetE ? op1 : bus.branchTargetE;
    assign bus.flagEQ         = flag_eq;
    assign bus.flagGT         = flag_gt;
endmodule
